// File: rtl/mouse_pkg.sv
// Shared definitions for the PS/2 mouse packet encoder: state encoding,
// header bit positions, datapath widths and the default report interval.
package mouse_pkg;

  localparam int unsigned ACC_W  = 9;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned BTN_W  = 3;
  localparam int unsigned IVL_W  = 16;

  localparam logic [IVL_W-1:0] DEFAULT_REPORT_INTERVAL = 16'd1000;

  // Header byte bit positions
  localparam int unsigned HDR_LEFT   = 0;
  localparam int unsigned HDR_RIGHT  = 1;
  localparam int unsigned HDR_MIDDLE = 2;
  localparam int unsigned HDR_ONE    = 3;
  localparam int unsigned HDR_X_SIGN = 4;
  localparam int unsigned HDR_Y_SIGN = 5;
  localparam int unsigned HDR_X_OVF  = 6;
  localparam int unsigned HDR_Y_OVF  = 7;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SEND_HDR = 2'd1,
    ST_SEND_DX  = 2'd2,
    ST_SEND_DY  = 2'd3
  } state_t;

  // Movement bytes captured at snapshot time
  typedef struct packed {
    logic [BYTE_W-1:0] dx;
    logic [BYTE_W-1:0] dy;
  } snap_t;

  // Assemble the packet header byte
  function automatic logic [BYTE_W-1:0] build_hdr(
    input logic             y_ovf,
    input logic             x_ovf,
    input logic             y_sign,
    input logic             x_sign,
    input logic [BTN_W-1:0] btn
  );
    logic [BYTE_W-1:0] h;
    h             = '0;
    h[HDR_LEFT]   = btn[0];
    h[HDR_RIGHT]  = btn[1];
    h[HDR_MIDDLE] = btn[2];
    h[HDR_ONE]    = 1'b1;
    h[HDR_X_SIGN] = x_sign;
    h[HDR_Y_SIGN] = y_sign;
    h[HDR_X_OVF]  = x_ovf;
    h[HDR_Y_OVF]  = y_ovf;
    return h;
  endfunction

endpackage

// File: rtl/sat_accum9.sv
// 9-bit signed saturating accumulator with sticky overflow flag.
// A clear that coincides with an add loads the add value so no motion is lost.
module sat_accum9
  import mouse_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              add_en,
  input  logic [BYTE_W-1:0] add_val,
  input  logic              clear,
  output logic [ACC_W-1:0]  acc,
  output logic              ovf
);

  localparam logic signed [ACC_W:0] SUM_MAX    = 10'sd255;
  localparam logic signed [ACC_W:0] SUM_MIN    = -10'sd256;
  localparam logic [ACC_W-1:0]      ACC_SAT_HI = 9'h0FF;
  localparam logic [ACC_W-1:0]      ACC_SAT_LO = 9'h100;

  logic signed [ACC_W:0] sum_c;
  logic                  sat_hi_c;
  logic                  sat_lo_c;

  // One-bit-wider sum so both saturation limits are detectable
  always_comb begin
    sum_c    = $signed({acc[ACC_W-1], acc})
             + $signed({{(ACC_W+1-BYTE_W){add_val[BYTE_W-1]}}, add_val});
    sat_hi_c = (sum_c > SUM_MAX);
    sat_lo_c = (sum_c < SUM_MIN);
  end

  // Accumulator and sticky overflow register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (clear) begin
      acc <= add_en ? {add_val[BYTE_W-1], add_val} : '0;
      ovf <= 1'b0;
    end else if (add_en) begin
      if (sat_hi_c) begin
        acc <= ACC_SAT_HI;
      end else if (sat_lo_c) begin
        acc <= ACC_SAT_LO;
      end else begin
        acc <= sum_c[ACC_W-1:0];
      end
      ovf <= ovf | sat_hi_c | sat_lo_c;
    end
  end

endmodule

// File: rtl/mouse_packet_encoder.sv
// PS/2 mouse packet encoder: accumulates motion, snapshots it together with
// button state and streams the three-byte packet over a valid/ready port,
// spacing packets by a programmable interval.
module mouse_packet_encoder
  import mouse_pkg::*;
#(
  parameter logic [IVL_W-1:0] REPORT_INTERVAL = DEFAULT_REPORT_INTERVAL
)
(
  input  logic              clk,
  input  logic              rst,
  input  logic [BYTE_W-1:0] move_x,
  input  logic [BYTE_W-1:0] move_y,
  input  logic              move_valid,
  input  logic [BTN_W-1:0]  buttons,
  output logic [BYTE_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
);

  // An interval of zero is treated as one
  localparam logic [IVL_W-1:0] IVL_LOAD =
    (REPORT_INTERVAL == '0) ? '0 : IVL_W'(REPORT_INTERVAL - 16'd1);

  state_t             state;
  logic [IVL_W-1:0]   ivl_cnt;
  logic [BTN_W-1:0]   last_buttons;
  snap_t              snap;

  logic [ACC_W-1:0]   acc_x;
  logic [ACC_W-1:0]   acc_y;
  logic               x_ovf;
  logic               y_ovf;

  logic               snap_c;
  logic               handshake_c;
  logic [BYTE_W-1:0]  hdr_c;

  // Per-axis saturating accumulators; cleared (or reloaded) on snapshot
  sat_accum9 u_acc_x (
    .clk     (clk),
    .rst     (rst),
    .add_en  (move_valid),
    .add_val (move_x),
    .clear   (snap_c),
    .acc     (acc_x),
    .ovf     (x_ovf)
  );

  sat_accum9 u_acc_y (
    .clk     (clk),
    .rst     (rst),
    .add_en  (move_valid),
    .add_val (move_y),
    .clear   (snap_c),
    .acc     (acc_y),
    .ovf     (y_ovf)
  );

  // Snapshot trigger, handshake and header assembly
  always_comb begin
    handshake_c = out_valid && out_ready;
    snap_c      = (state == ST_IDLE) && (ivl_cnt == '0) &&
                  ((acc_x != '0) || (acc_y != '0) || (buttons != last_buttons));
    hdr_c       = build_hdr(y_ovf, x_ovf, acc_y[ACC_W-1], acc_x[ACC_W-1], buttons);
  end

  // Packet sequencer with registered out_valid/out_data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      out_valid    <= 1'b0;
      out_data     <= '0;
      last_buttons <= '0;
      ivl_cnt      <= '0;
      snap         <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (ivl_cnt != '0) begin
            ivl_cnt <= ivl_cnt - 16'd1;
          end
          if (snap_c) begin
            snap.dx      <= acc_x[BYTE_W-1:0];
            snap.dy      <= acc_y[BYTE_W-1:0];
            last_buttons <= buttons;
            out_data     <= hdr_c;
            out_valid    <= 1'b1;
            state        <= ST_SEND_HDR;
          end
        end
        ST_SEND_HDR: begin
          if (handshake_c) begin
            out_data <= snap.dx;
            state    <= ST_SEND_DX;
          end
        end
        ST_SEND_DX: begin
          if (handshake_c) begin
            out_data <= snap.dy;
            state    <= ST_SEND_DY;
          end
        end
        ST_SEND_DY: begin
          if (handshake_c) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            ivl_cnt   <= IVL_LOAD;
            state     <= ST_IDLE;
          end
        end
        default: begin
          state     <= ST_IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
